// File: rtl/tank_multishot_if.sv
// Bundle between the input/AI decoders, brick-map owner and sprite renderer.
// Pure wiring, no latency.
// No backpressure: every signal is sampled or updated once per frame.
interface tank_multishot_if #(
    parameter int NUM_BULLETS = 2
);
    logic                       move_up;
    logic                       move_down;
    logic                       move_left;
    logic                       move_right;
    logic                       fire;
    logic [39:0]                brick_map [30];
    logic [9:0]                 tank_x;
    logic [9:0]                 tank_y;
    logic [3:0]                 tank_dir;
    logic [NUM_BULLETS-1:0]     bullet_active;
    logic [10*NUM_BULLETS-1:0]  bullet_x;
    logic [10*NUM_BULLETS-1:0]  bullet_y;
    logic [4*NUM_BULLETS-1:0]   bullet_dir;
    logic                       hit_valid;
    logic [4:0]                 hit_row;
    logic [5:0]                 hit_col;
    logic [1:0]                 hit_slot;

    modport master (
        output move_up, move_down, move_left, move_right, fire, brick_map,
        input  tank_x, tank_y, tank_dir, bullet_active, bullet_x, bullet_y, bullet_dir,
        input  hit_valid, hit_row, hit_col, hit_slot
    );

    modport slave (
        input  move_up, move_down, move_left, move_right, fire, brick_map,
        output tank_x, tank_y, tank_dir, bullet_active, bullet_x, bullet_y, bullet_dir,
        output hit_valid, hit_row, hit_col, hit_slot
    );
endinterface

// File: rtl/tank_multishot.sv
// Tank controller: movement with brick collision, multi-slot bullets, fire cooldown, brick-hit report.
// Latency: every output is registered, one frame_clk after the inputs that cause it.
// No backpressure: fire edges arriving during cooldown or with all slots busy are dropped.
module tank_multishot #(
    parameter int          NUM_BULLETS   = 2,
    parameter int          TANK_STEP     = 2,
    parameter int          BULLET_SPEED  = 8,
    parameter int          FIRE_COOLDOWN = 8,
    parameter int          SPAWN_X       = 230,
    parameter int          SPAWN_Y       = 240,
    parameter logic [3:0]  SPAWN_DIR     = 4'b0001,
    parameter int          X_MIN         = 80,
    parameter int          X_MAX         = 528,
    parameter int          Y_MIN         = 0,
    parameter int          Y_MAX         = 448
) (
    input  logic                i_frame_clk,
    input  logic                i_reset_n,
    tank_multishot_if.slave     bus
);
    localparam logic [3:0] DIR_UP = 4'b0001;
    localparam logic [3:0] DIR_DN = 4'b0010;
    localparam logic [3:0] DIR_LT = 4'b0100;
    localparam logic [3:0] DIR_RT = 4'b1000;
    localparam logic [9:0] BSPD      = 10'(BULLET_SPEED);
    localparam logic [7:0] COOL_LOAD = 8'(FIRE_COOLDOWN);

    // state
    logic [9:0]             r_tank_x;
    logic [9:0]             r_tank_y;
    logic [3:0]             r_tank_dir;
    logic [NUM_BULLETS-1:0] r_act;
    logic [9:0]             r_bx   [NUM_BULLETS];
    logic [9:0]             r_by   [NUM_BULLETS];
    logic [3:0]             r_bdir [NUM_BULLETS];
    logic [7:0]             r_cool;
    logic                   r_fire_q;
    logic                   r_hit_valid;
    logic [4:0]             r_hit_row;
    logic [5:0]             r_hit_col;
    logic [1:0]             r_hit_slot;

    // next-state wires
    logic [39:0]            w_map  [30];
    int                     w_cx;
    int                     w_cy;
    logic                   w_mv_req;
    logic                   w_mv_ok;
    logic [3:0]             w_mv_dir;
    logic [9:0]             w_spx;
    logic [9:0]             w_spy;
    logic                   w_fire_edge;
    logic                   w_accept;
    logic [NUM_BULLETS-1:0] w_spawn_mask;
    logic [9:0]             w_nx   [NUM_BULLETS];
    logic [9:0]             w_ny   [NUM_BULLETS];
    logic [9:0]             w_nx7  [NUM_BULLETS];
    logic [9:0]             w_ny7  [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] w_nact;
    logic [NUM_BULLETS-1:0] w_bhit;
    logic [4:0]             w_brow [NUM_BULLETS];
    logic [5:0]             w_bcol [NUM_BULLETS];
    logic                   w_hit_any;
    logic [4:0]             w_hit_row;
    logic [5:0]             w_hit_col;
    logic [1:0]             w_hit_slot;

    for (genvar g = 0; g < 30; g++) begin : g_map
        assign w_map[g] = bus.brick_map[g];
    end

    // Cells outside the 40x30 map never hold a brick, so wrapped coordinates read as empty.
    function automatic logic cell_brick(input logic [9:0] x, input logic [9:0] y);
        logic [5:0] col;
        logic [5:0] row;
        col = x[9:4];
        row = y[9:4];
        if (row >= 6'd30 || col >= 6'd40) return 1'b0;
        return w_map[row[4:0]][6'd39 - col];
    endfunction

    // Nine-point probe of the 32x32 tank footprint.
    function automatic logic tank_blocked(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] ofs [3];
        logic       blk;
        ofs[0] = 10'd0;
        ofs[1] = 10'd15;
        ofs[2] = 10'd31;
        blk    = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                blk = blk | cell_brick(x + ofs[i], y + ofs[j]);
        return blk;
    endfunction

    // Tank movement: prioritised request, bounds check, brick collision; facing always follows the request.
    always_comb begin
        w_mv_req = 1'b1;
        w_mv_dir = r_tank_dir;
        w_cx     = int'(r_tank_x);
        w_cy     = int'(r_tank_y);
        if (bus.move_up) begin
            w_mv_dir = DIR_UP;
            w_cy     = int'(r_tank_y) - TANK_STEP;
        end else if (bus.move_down) begin
            w_mv_dir = DIR_DN;
            w_cy     = int'(r_tank_y) + TANK_STEP;
        end else if (bus.move_left) begin
            w_mv_dir = DIR_LT;
            w_cx     = int'(r_tank_x) - TANK_STEP;
        end else if (bus.move_right) begin
            w_mv_dir = DIR_RT;
            w_cx     = int'(r_tank_x) + TANK_STEP;
        end else begin
            w_mv_req = 1'b0;
        end
        w_mv_ok = w_mv_req && (w_cx >= X_MIN) && (w_cx <= X_MAX) &&
                  (w_cy >= Y_MIN) && (w_cy <= Y_MAX) &&
                  !tank_blocked(w_cx[9:0], w_cy[9:0]);
    end

    // Spawn point in front of the tank, from the pre-move position and facing.
    always_comb begin
        w_spx = r_tank_x + 10'd12;
        w_spy = r_tank_y - 10'd8;
        case (r_tank_dir)
            DIR_DN: begin w_spx = r_tank_x + 10'd12; w_spy = r_tank_y + 10'd32; end
            DIR_LT: begin w_spx = r_tank_x - 10'd8;  w_spy = r_tank_y + 10'd12; end
            DIR_RT: begin w_spx = r_tank_x + 10'd32; w_spy = r_tank_y + 10'd12; end
            default: ;
        endcase
    end

    // Fire acceptance: rising edge, cooldown expired, lowest slot idle at the start of the frame.
    always_comb begin
        w_fire_edge  = bus.fire & ~r_fire_q;
        w_spawn_mask = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!r_act[i]) begin
                w_spawn_mask    = '0;
                w_spawn_mask[i] = 1'b1;
            end
        end
        w_accept = w_fire_edge && (r_cool == 8'd0) && (w_spawn_mask != '0);
    end

    // Bullet step and retire: leave the field or touch a brick at any corner of the next position.
    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_nx[i]   = r_bx[i];
            w_ny[i]   = r_by[i];
            w_nact[i] = r_act[i];
            w_bhit[i] = 1'b0;
            w_brow[i] = '0;
            w_bcol[i] = '0;
            if (r_act[i]) begin
                case (r_bdir[i])
                    DIR_UP:  w_ny[i] = r_by[i] - BSPD;
                    DIR_DN:  w_ny[i] = r_by[i] + BSPD;
                    DIR_LT:  w_nx[i] = r_bx[i] - BSPD;
                    DIR_RT:  w_nx[i] = r_bx[i] + BSPD;
                    default: ;
                endcase
            end
            w_nx7[i] = w_nx[i] + 10'd7;
            w_ny7[i] = w_ny[i] + 10'd7;
            if (r_act[i]) begin
                if (cell_brick(w_nx[i], w_ny[i])) begin
                    w_bhit[i] = 1'b1; w_brow[i] = w_ny[i][8:4];  w_bcol[i] = w_nx[i][9:4];
                end else if (cell_brick(w_nx7[i], w_ny[i])) begin
                    w_bhit[i] = 1'b1; w_brow[i] = w_ny[i][8:4];  w_bcol[i] = w_nx7[i][9:4];
                end else if (cell_brick(w_nx[i], w_ny7[i])) begin
                    w_bhit[i] = 1'b1; w_brow[i] = w_ny7[i][8:4]; w_bcol[i] = w_nx[i][9:4];
                end else if (cell_brick(w_nx7[i], w_ny7[i])) begin
                    w_bhit[i] = 1'b1; w_brow[i] = w_ny7[i][8:4]; w_bcol[i] = w_nx7[i][9:4];
                end
                if (w_bhit[i] || (int'(w_nx[i]) + 8 < X_MIN) ||
                    (int'(w_nx[i]) > X_MAX + 32) || (int'(w_ny[i]) > Y_MAX + 32))
                    w_nact[i] = 1'b0;
            end
        end
    end

    // Hit report arbitration: the lowest hitting slot wins.
    always_comb begin
        w_hit_any  = |w_bhit;
        w_hit_row  = '0;
        w_hit_col  = '0;
        w_hit_slot = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (w_bhit[i]) begin
                w_hit_row  = w_brow[i];
                w_hit_col  = w_bcol[i];
                w_hit_slot = 2'(i);
            end
        end
    end

    // Frame-rate state update; a spawn overrides the retire/step result of its slot.
    always_ff @(posedge i_frame_clk) begin
        if (!i_reset_n) begin
            r_tank_x    <= 10'(SPAWN_X);
            r_tank_y    <= 10'(SPAWN_Y);
            r_tank_dir  <= SPAWN_DIR;
            r_act       <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_bx[i]   <= '0;
                r_by[i]   <= '0;
                r_bdir[i] <= DIR_UP;
            end
            r_cool      <= '0;
            r_fire_q    <= 1'b0;
            r_hit_valid <= 1'b0;
            r_hit_row   <= '0;
            r_hit_col   <= '0;
            r_hit_slot  <= '0;
        end else begin
            r_tank_dir <= w_mv_dir;
            if (w_mv_ok) begin
                r_tank_x <= w_cx[9:0];
                r_tank_y <= w_cy[9:0];
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (w_accept && w_spawn_mask[i]) begin
                    r_act[i]  <= 1'b1;
                    r_bx[i]   <= w_spx;
                    r_by[i]   <= w_spy;
                    r_bdir[i] <= r_tank_dir;
                end else begin
                    r_act[i]  <= w_nact[i];
                    r_bx[i]   <= w_nx[i];
                    r_by[i]   <= w_ny[i];
                end
            end
            if (w_accept)
                r_cool <= COOL_LOAD;
            else if (r_cool != 8'd0)
                r_cool <= r_cool - 8'd1;
            r_fire_q    <= bus.fire;
            r_hit_valid <= w_hit_any;
            if (w_hit_any) begin
                r_hit_row  <= w_hit_row;
                r_hit_col  <= w_hit_col;
                r_hit_slot <= w_hit_slot;
            end
        end
    end

    assign bus.tank_x        = r_tank_x;
    assign bus.tank_y        = r_tank_y;
    assign bus.tank_dir      = r_tank_dir;
    assign bus.bullet_active = r_act;
    assign bus.hit_valid     = r_hit_valid;
    assign bus.hit_row       = r_hit_row;
    assign bus.hit_col       = r_hit_col;
    assign bus.hit_slot      = r_hit_slot;

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
        assign bus.bullet_x[10*g +: 10] = r_bx[g];
        assign bus.bullet_y[10*g +: 10] = r_by[g];
        assign bus.bullet_dir[4*g +: 4] = r_bdir[g];
    end
endmodule

// File: tb/tb_tank_multishot.sv
// Directed bench for tank_multishot: reset, movement, cooldown, slot allocation, brick hit, wrap retire.
// Outputs are sampled 1 time unit after each rising frame_clk edge.
// Inputs are driven at the same point, so they are seen at the next edge.
module tb_tank_multishot;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    tank_multishot_if #(.NUM_BULLETS(2)) bus ();

    tank_multishot #(.NUM_BULLETS(2)) dut (
        .i_frame_clk (clk),
        .i_reset_n   (rst_n),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic moves(input logic u, input logic d, input logic l, input logic r);
        bus.move_up    = u;
        bus.move_down  = d;
        bus.move_left  = l;
        bus.move_right = r;
    endtask

    initial begin
        moves(0, 0, 0, 0);
        bus.fire = 1'b0;
        for (int r = 0; r < 30; r++) bus.brick_map[r] = '0;

        // 1) reset
        ticks(2);
        chk("rst_tank_x", 32'(bus.tank_x), 230);
        chk("rst_tank_y", 32'(bus.tank_y), 240);
        chk("rst_dir", 32'(bus.tank_dir), 1);
        chk("rst_active", 32'(bus.bullet_active), 0);
        chk("rst_hit_valid", 32'(bus.hit_valid), 0);
        chk("rst_bullet_x", 32'(bus.bullet_x), 0);
        chk("rst_bullet_dir", 32'(bus.bullet_dir), 32'h11);
        rst_n = 1'b1;

        // 2) movement and priority
        moves(1, 0, 0, 0);
        ticks(5);
        chk("up5_y", 32'(bus.tank_y), 230);
        chk("up5_dir", 32'(bus.tank_dir), 1);
        moves(1, 0, 1, 0);
        tick();
        chk("upleft_y", 32'(bus.tank_y), 228);
        chk("upleft_x", 32'(bus.tank_x), 230);
        moves(0, 0, 0, 0);

        // 3) fire toggling with cooldown and two slots
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        bus.fire = 1'b1; tick();
        chk("f0_active", 32'(bus.bullet_active), 1);
        chk("f0_x", 32'(bus.bullet_x[9:0]), 242);
        chk("f0_y", 32'(bus.bullet_y[9:0]), 232);
        chk("f0_dir", 32'(bus.bullet_dir[3:0]), 1);
        for (int k = 1; k <= 9; k++) begin
            bus.fire = (k % 2 == 0);
            tick();
        end
        chk("cool_active", 32'(bus.bullet_active), 1);
        chk("cool_y0", 32'(bus.bullet_y[9:0]), 160);
        bus.fire = 1'b1; tick();
        chk("f10_active", 32'(bus.bullet_active), 3);
        chk("f10_x1", 32'(bus.bullet_x[19:10]), 242);
        chk("f10_y1", 32'(bus.bullet_y[19:10]), 232);
        chk("f10_y0", 32'(bus.bullet_y[9:0]), 152);
        for (int k = 11; k <= 19; k++) begin
            bus.fire = (k % 2 == 0);
            tick();
        end
        bus.fire = 1'b1; tick();
        chk("full_active", 32'(bus.bullet_active), 3);
        chk("full_y0", 32'(bus.bullet_y[9:0]), 72);
        chk("full_y1", 32'(bus.bullet_y[19:10]), 152);

        // 6) reset with bullets in flight, then fire straight after
        rst_n = 1'b0; bus.fire = 1'b0; tick();
        chk("midrst_active", 32'(bus.bullet_active), 0);
        chk("midrst_x", 32'(bus.tank_x), 230);
        rst_n = 1'b1; bus.fire = 1'b1; tick();
        chk("postrst_active", 32'(bus.bullet_active), 1);
        chk("postrst_y0", 32'(bus.bullet_y[9:0]), 232);
        rst_n = 1'b0; bus.fire = 1'b0; tick();
        rst_n = 1'b1; bus.fire = 1'b1; tick();
        chk("coolclr_active", 32'(bus.bullet_active), 1);
        bus.fire = 1'b0;

        // right-facing spawn and step
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        moves(0, 0, 0, 1); ticks(6); moves(0, 0, 0, 0);
        chk("right_x", 32'(bus.tank_x), 242);
        chk("right_dir", 32'(bus.tank_dir), 8);
        bus.fire = 1'b1; tick();
        chk("rspawn_x", 32'(bus.bullet_x[9:0]), 274);
        chk("rspawn_y", 32'(bus.bullet_y[9:0]), 252);
        chk("rspawn_dir", 32'(bus.bullet_dir[3:0]), 8);
        bus.fire = 1'b0; tick();
        chk("rstep_x", 32'(bus.bullet_x[9:0]), 282);

        // 4) brick hit report
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        moves(0, 0, 0, 1); ticks(6);
        moves(1, 0, 0, 0); ticks(20);
        moves(0, 0, 0, 0);
        chk("pos_x", 32'(bus.tank_x), 242);
        chk("pos_y", 32'(bus.tank_y), 200);
        bus.brick_map[10][24] = 1'b1;
        bus.fire = 1'b1; tick();
        chk("hspawn_y", 32'(bus.bullet_y[9:0]), 192);
        bus.fire = 1'b0; ticks(2);
        chk("hpre_active", 32'(bus.bullet_active), 1);
        chk("hpre_y", 32'(bus.bullet_y[9:0]), 176);
        chk("hpre_valid", 32'(bus.hit_valid), 0);
        tick();
        chk("hit_active", 32'(bus.bullet_active), 0);
        chk("hit_valid", 32'(bus.hit_valid), 1);
        chk("hit_row", 32'(bus.hit_row), 10);
        chk("hit_col", 32'(bus.hit_col), 15);
        chk("hit_slot", 32'(bus.hit_slot), 0);
        tick();
        chk("hit_pulse_end", 32'(bus.hit_valid), 0);

        // tank blocked by the same brick
        moves(1, 0, 0, 0); ticks(15);
        chk("blocked_y", 32'(bus.tank_y), 176);

        // 5) climb to the top edge, fire up, bullet wraps and retires silently
        bus.brick_map[10] = '0;
        ticks(92);
        moves(0, 0, 0, 0);
        chk("top_y", 32'(bus.tank_y), 0);
        bus.fire = 1'b1; tick();
        chk("wrap_active", 32'(bus.bullet_active), 1);
        chk("wrap_y", 32'(bus.bullet_y[9:0]), 1016);
        bus.fire = 1'b0; tick();
        chk("wrap_retire", 32'(bus.bullet_active), 0);
        chk("wrap_no_hit", 32'(bus.hit_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
